// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Produces ones/tens/hundreds BCD digits for the display mux and holds them between conversions.
// Optional build macro: BIN2BCD_SATURATE_EN forces 9/9/9 on overflow (value > 999).
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       hex0char,
  output logic [3:0]       hex1char,
  output logic [3:0]       hex2char
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sreg, sreg_nxt;
  logic [BCD_W-1:0]  scratch, scratch_nxt, adj;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, overflow_nxt;
  logic [3:0]        hex0_nxt, hex1_nxt, hex2_nxt;
  logic              ovf_c;

  // Add 3 to every scratch digit that is 5 or more, ahead of the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Thousands digit non-zero means the value does not fit in three digits
  assign ovf_c = |scratch[15:12];

  // Next-state and next-register logic
  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    scratch_nxt  = scratch;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    overflow_nxt = overflow;
    hex0_nxt     = hex0char;
    hex1_nxt     = hex1char;
    hex2_nxt     = hex2char;

    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt    = bin_in;
          scratch_nxt = '0;
          cnt_nxt     = '0;
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_nxt, sreg_nxt} = {adj, sreg} << 1;
        cnt_nxt = cnt + CNT_W'(1);
        // Terminal compare at WIDTH-1 keeps the 4-bit counter from wrapping
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        overflow_nxt = ovf_c;
`ifdef BIN2BCD_SATURATE_EN
        if (ovf_c) begin
          hex0_nxt = 4'd9;
          hex1_nxt = 4'd9;
          hex2_nxt = 4'd9;
        end else begin
          hex0_nxt = scratch[3:0];
          hex1_nxt = scratch[7:4];
          hex2_nxt = scratch[11:8];
        end
`else
        hex0_nxt = scratch[3:0];
        hex1_nxt = scratch[7:4];
        hex2_nxt = scratch[11:8];
`endif
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      hex0char <= 4'd0;
      hex1char <= 4'd0;
      hex2char <= 4'd0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      scratch  <= scratch_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      overflow <= overflow_nxt;
      hex0char <= hex0_nxt;
      hex1char <= hex1_nxt;
      hex2char <= hex2_nxt;
    end
  end

endmodule
